spi_tx_feeder: RTL and testbench
================================

SPI_TX_FEEDER -- requirements
Module: spi_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes; power of two, 4..256.
REQ-002 SHALL have parameter FILL_BYTE, default 8'hFF, byte sent when the FIFO is dry.
REQ-003 SHALL have parameter HOLD_MAX, default 4, maximum cycles to wait for phy empty to drop after a push.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports wr_en / wr_data, input, 1 / 8, host byte write, accepted when wr_en && !full.
REQ-007 SHALL have port full, output, 1, FIFO holds DEPTH bytes.
REQ-008 SHALL have port level, output, $clog2(DEPTH)+1, current FIFO occupancy.
REQ-009 SHALL have port momment_cfg, input, 24, requested bit position of first transmitted byte.
REQ-010 SHALL have ports send_flag / empty, input, 1 / 1, from the SPI TX phy: frame active and phy needs a byte.
REQ-011 SHALL have ports send_data / send_valid / send_momment, output, 8 / 1 / 24, to the SPI TX phy.
REQ-012 SHALL have ports frame_done / underrun / underrun_cnt, output, 1 / 1 / 16: end-of-frame pulse, sticky dry flag, dry-push count.

Function
REQ-013 SHALL run FSM states IDLE, WAIT, PUSH, HOLD.
REQ-014 SHALL move IDLE->WAIT on the first cycle send_flag is high, latching momment_cfg into send_momment and clearing underrun.
REQ-015 SHALL move WAIT->PUSH when empty is high.
REQ-016 SHALL drive send_valid high for exactly the one PUSH cycle, then go to HOLD.
REQ-017 SHALL leave HOLD->WAIT when empty is low, or after HOLD_MAX cycles in HOLD, whichever comes first.
REQ-018 SHALL return to IDLE from any state on the cycle send_flag is low, pulsing frame_done for one cycle if the state was not IDLE.
REQ-019 SHALL, in PUSH with FIFO non-empty, pop one byte and present it on send_data in the same cycle; the FIFO is first-word-fall-through.
REQ-020 SHALL, in PUSH with FIFO empty, present FILL_BYTE, set underrun, and increment underrun_cnt saturating at 16'hFFFF.
REQ-021 SHALL ignore writes when full (no overwrite); a simultaneous write and pop when full SHALL complete both, leaving level unchanged.
REQ-022 SHALL treat a simultaneous write and pop when empty as an underrun; the written byte is stored.
REQ-023 SHALL keep send_data stable outside PUSH (last value held).
REQ-024 SHALL wrap FIFO pointers modulo DEPTH; level SHALL be exact from 0 to DEPTH.

Reset
REQ-025 SHALL, on rst, force: state IDLE, FIFO empty, level 0, full 0, send_valid 0, send_data 8'h00, send_momment 24'd0, frame_done 0, underrun 0, underrun_cnt 0.
REQ-026 SHALL, on rst asserted mid-frame, discard FIFO content and produce no frame_done pulse.

Configuration
REQ-027 SHALL compile the underrun counter only when macro SPI_TX_FEEDER_UNDERRUN_CNT_EN is defined; otherwise underrun_cnt is tied to 16'd0, while underrun and FILL_BYTE substitution are unchanged.

Structure
REQ-028 SHALL place the FSM state enumeration and the FILL_BYTE default constant in shared package spi_phy_pkg.
REQ-029 SHALL implement storage as one sub-module, sync_fifo_fwft (DEPTH, 8-bit width, level output).

Verification
REQ-030 SHALL cover: write 3 bytes A1,B2,C3; send_flag high; empty pulsed 3 times -> send_valid 3 single-cycle pulses carrying A1,B2,C3; level 3->0.
REQ-031 SHALL cover: FIFO empty, send_flag high, empty high -> send_data 8'hFF, underrun 1, underrun_cnt 1; with macro undefined, underrun_cnt 0.
REQ-032 SHALL cover: empty stuck high after a push -> next send_valid exactly HOLD_MAX+2 cycles after the previous one.
REQ-033 SHALL cover: write 17 bytes with DEPTH=16 -> full 1 after 16, 17th dropped, level 16; pop + write when full -> level stays 16.
REQ-034 SHALL cover: momment_cfg=24'd40 at send_flag rise, changed to 24'd8 mid-frame -> send_momment stays 40; send_flag falls -> frame_done pulses once, state IDLE.
REQ-035 SHALL cover: rst asserted in HOLD with level 5 -> all outputs at reset values immediately, level 0, no frame_done.

Source files
------------

// File: rtl/spi_phy_pkg.sv
// Shared definitions for the SPI TX feeder path.
//   feeder_state_t    : feeder FSM state encoding
//   FILL_BYTE_DEFAULT : byte sent to the phy when the FIFO is dry
//   sat_inc16         : 16-bit saturating increment
package spi_phy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PUSH = 2'd2,
        ST_HOLD = 2'd3
    } feeder_state_t;

    localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/spi_tx_feeder_if.sv
// Feeder <-> SPI TX phy handshake.
//   send_flag    : phy -> feeder, frame active
//   empty        : phy -> feeder, phy needs a byte
//   send_data    : feeder -> phy, byte to transmit
//   send_valid   : feeder -> phy, one-cycle strobe for send_data
//   send_momment : feeder -> phy, bit position of first transmitted byte
// master = feeder side, slave = phy side.
interface spi_tx_feeder_if;
    logic        send_flag;
    logic        empty;
    logic [7:0]  send_data;
    logic        send_valid;
    logic [23:0] send_momment;

    modport master (
        input  send_flag, empty,
        output send_data, send_valid, send_momment
    );

    modport slave (
        output send_flag, empty,
        input  send_data, send_valid, send_momment
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
//   clock, rst        : clock, asynchronous active-high reset
//   wr_en, wr_data    : write; accepted when not full, or when full and a
//                       pop happens in the same cycle
//   rd_en             : pop; ignored while empty
//   rd_data           : head entry, valid whenever !empty
//   full, empty, level: occupancy status (level exact from 0 to DEPTH)
module sync_fifo_fwft #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr, do_rd;

    assign empty   = (cnt == '0);
    assign full    = (cnt == LVL_FULL);
    assign level   = cnt;
    assign rd_data = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO still takes a write then.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + LVL_ONE;
                2'b01:   cnt <= cnt - LVL_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/spi_tx_feeder.sv
// Byte feeder between a host write port and an SPI TX phy.
// Host writes land in a FWFT FIFO; each time the phy raises empty during a
// frame, one byte is popped and strobed out with send_valid. A dry FIFO sends
// FILL_BYTE and flags underrun.
//   clock, rst              : clock, asynchronous active-high reset
//   wr_en, wr_data          : host byte write
//   full, level             : FIFO status
//   momment_cfg             : first-byte bit position, latched at frame start
//   phy (master)            : send_flag/empty in, send_data/send_valid/send_momment out
//   frame_done              : one-cycle pulse when a frame ends
//   underrun, underrun_cnt  : sticky dry flag (cleared at frame start), dry-push count
// Optional: define SPI_TX_FEEDER_UNDERRUN_CNT_EN to build the underrun
// counter; otherwise underrun_cnt reads 0.
module spi_tx_feeder
    import spi_phy_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT,
    parameter int         HOLD_MAX  = 4
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    input  logic [23:0]            momment_cfg,
    spi_tx_feeder_if.master        phy,
    output logic                   frame_done,
    output logic                   underrun,
    output logic [15:0]            underrun_cnt
);
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
    localparam logic [HW-1:0] HOLD_ONE  = 1;

    feeder_state_t state;
    logic [HW-1:0] hold_cnt;
    logic          valid_q;
    logic [7:0]    data_q;
    logic [23:0]   momment_q;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic          push_go;

    // The pop happens on the edge that enters PUSH, so the byte is already
    // registered on send_data for the whole PUSH cycle.
    assign push_go = (state == ST_WAIT) && phy.send_flag && phy.empty;

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock   (clock),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (push_go),
        .rd_data (fifo_head),
        .full    (full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign phy.send_valid   = valid_q;
    assign phy.send_data    = data_q;
    assign phy.send_momment = momment_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            valid_q    <= 1'b0;
            data_q     <= 8'h00;
            momment_q  <= 24'd0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            frame_done <= 1'b0;
            // A dropped send_flag ends the frame from any state.
            if (!phy.send_flag) begin
                if (state != ST_IDLE) frame_done <= 1'b1;
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_WAIT;
                        momment_q <= momment_cfg;
                        underrun  <= 1'b0;
                    end
                    ST_WAIT: begin
                        if (phy.empty) begin
                            state   <= ST_PUSH;
                            valid_q <= 1'b1;
                            if (fifo_empty) begin
                                data_q   <= FILL_BYTE;
                                underrun <= 1'b1;
                            end else begin
                                data_q <= fifo_head;
                            end
                        end
                    end
                    ST_PUSH: begin
                        state    <= ST_HOLD;
                        hold_cnt <= '0;
                    end
                    ST_HOLD: begin
                        // Give the phy up to HOLD_MAX cycles to drop empty
                        // so one request is not served twice.
                        if (!phy.empty || hold_cnt == HOLD_LAST) state <= ST_WAIT;
                        else hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SPI_TX_FEEDER_UNDERRUN_CNT_EN
    logic [15:0] urun_cnt_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) urun_cnt_q <= 16'd0;
        else if (push_go && fifo_empty) urun_cnt_q <= sat_inc16(urun_cnt_q);
    end

    assign underrun_cnt = urun_cnt_q;
`else
    assign underrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Self-checking bench for spi_tx_feeder (default parameters).
// A queue-based model tracks FIFO content, frame activity, momment latch and
// underrun status, and is compared against the DUT every cycle; directed
// sequences pin literal values and push timing.
module tb_spi_tx_feeder;
    import spi_phy_pkg::*;

    localparam int         DEPTH = 16;
    localparam logic [7:0] FILL  = 8'hFF;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic [23:0] momment_cfg = 24'd0;
    logic        full;
    logic [4:0]  level;
    logic        frame_done;
    logic        underrun;
    logic [15:0] underrun_cnt;

    spi_tx_feeder_if phy();

    spi_tx_feeder dut (
        .clock        (clock),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .level        (level),
        .momment_cfg  (momment_cfg),
        .phy          (phy),
        .frame_done   (frame_done),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sv_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Inputs as seen by the DUT at the last rising edge.
    logic        s_rst, s_wr, s_flag;
    logic [7:0]  s_d;
    logic [23:0] s_cfg;
    always @(posedge clock) begin
        cyc++;
        s_rst  <= rst;
        s_wr   <= wr_en;
        s_d    <= wr_data;
        s_flag <= phy.send_flag;
        s_cfg  <= momment_cfg;
    end

    // Behavioural model + per-cycle compare.
    logic [7:0]  q[$];
    logic        m_frame, m_under, prev_sv, exp_fd;
    logic [23:0] m_mom;
    logic [15:0] m_cnt;
    logic [7:0]  m_data;
    int          n;

    always @(negedge clock) begin
        if (rst || s_rst) begin
            q.delete();
            m_frame = 1'b0; m_under = 1'b0; m_mom = 24'd0;
            m_cnt = 16'd0; m_data = 8'h00; prev_sv = 1'b0;
        end else begin
            n = q.size();
            exp_fd = 1'b0;
            if (s_flag) begin
                if (!m_frame) begin
                    m_frame = 1'b1; m_mom = s_cfg; m_under = 1'b0;
                end
            end else begin
                exp_fd = m_frame;
                m_frame = 1'b0;
            end
            if (phy.send_valid) begin
                sv_count++;
                if (n > 0) m_data = q.pop_front();
                else begin
                    m_data = FILL;
                    m_under = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
            end
            if (s_wr && (n < DEPTH || phy.send_valid)) q.push_back(s_d);

            chk("m_level", 32'(level), 32'(q.size()));
            chk("m_full", 32'(full), 32'(q.size() == DEPTH));
            chk("m_send_data", 32'(phy.send_data), 32'(m_data));
            chk("m_momment", 32'(phy.send_momment), 32'(m_mom));
            chk("m_frame_done", 32'(frame_done), 32'(exp_fd));
            chk("m_underrun", 32'(underrun), 32'(m_under));
`ifdef SPI_TX_FEEDER_UNDERRUN_CNT_EN
            chk("m_underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
`else
            chk("m_underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif
            chk("m_valid_single", 32'(prev_sv && phy.send_valid), 32'd0);
            chk("m_valid_in_frame", 32'(phy.send_valid && !m_frame), 32'd0);
            prev_sv = phy.send_valid;
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(output logic [7:0] d, output int t);
        bit got = 0;
        d = 8'h00;
        t = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (phy.send_valid) begin
                got = 1; d = phy.send_data; t = cyc;
            end
        end
        chk("valid_seen", 32'(got), 32'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, 32'(phy.send_valid), 32'd0);
        chk({tag, "_data"}, 32'(phy.send_data), 32'h00);
        chk({tag, "_momment"}, 32'(phy.send_momment), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_underrun"}, 32'(underrun), 32'd0);
        chk({tag, "_underrun_cnt"}, 32'(underrun_cnt), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_state"}, 32'(dut.state), 32'(ST_IDLE));
    endtask

    logic [7:0] d;
    logic [7:0] exp3 [3];
    int t1, t2, sv0, fd;

    initial begin
        phy.send_flag = 1'b0;
        phy.empty = 1'b0;
        exp3 = '{8'hA1, 8'hB2, 8'hC3};

        // Reset state
        step(2);
        chk_reset_outs("rst");
        rst = 1'b0;
        step(2);

        // Three bytes out in order, one strobe each
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = exp3[i];
            step(1);
        end
        wr_en = 1'b0;
        chk("fill3_level", 32'(level), 32'd3);
        sv0 = sv_count;
        phy.send_flag = 1'b1;
        step(2);
        for (int i = 0; i < 3; i++) begin
            phy.empty = 1'b1;
            wait_valid(d, t1);
            chk("seq_data", 32'(d), 32'(exp3[i]));
            step(1);
            phy.empty = 1'b0;
            step(3);
        end
        chk("seq_level", 32'(level), 32'd0);
        chk("seq_pulses", 32'(sv_count - sv0), 32'd3);
        phy.send_flag = 1'b0;
        step(3);

        // Dry FIFO and empty stuck high: fill byte, underrun, repeat period
        phy.send_flag = 1'b1;
        phy.empty = 1'b1;
        wait_valid(d, t1);
        chk("dry_data", 32'(d), 32'hFF);
        chk("dry_underrun", 32'(underrun), 32'd1);
`ifdef SPI_TX_FEEDER_UNDERRUN_CNT_EN
        chk("dry_cnt1", 32'(underrun_cnt), 32'd1);
`else
        chk("dry_cnt1", 32'(underrun_cnt), 32'd0);
`endif
        wait_valid(d, t2);
        chk("stuck_period", 32'(t2 - t1), 32'd6);
`ifdef SPI_TX_FEEDER_UNDERRUN_CNT_EN
        chk("dry_cnt2", 32'(underrun_cnt), 32'd2);
`else
        chk("dry_cnt2", 32'(underrun_cnt), 32'd0);
`endif
        step(1);
        phy.empty = 1'b0;
        phy.send_flag = 1'b0;
        step(3);

        // Overfill: 17 writes, 17th dropped; pop + write while full
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
            step(1);
            if (i == 15) begin
                chk("full16_full", 32'(full), 32'd1);
                chk("full16_level", 32'(level), 32'd16);
            end
        end
        wr_en = 1'b0;
        chk("full17_level", 32'(level), 32'd16);
        chk("full17_full", 32'(full), 32'd1);
        phy.send_flag = 1'b1;
        step(2);
        phy.empty = 1'b1;
        wr_en = 1'b1; wr_data = 8'hEE;
        wait_valid(d, t1);
        chk("full_pop_data", 32'(d), 32'h10);
        chk("full_pop_level", 32'(level), 32'd16);
        step(1);
        wr_en = 1'b0;
        phy.empty = 1'b0;
        phy.send_flag = 1'b0;
        step(3);

        // momment latched at frame start; frame_done single pulse
        momment_cfg = 24'd40;
        phy.send_flag = 1'b1;
        step(3);
        momment_cfg = 24'd8;
        step(2);
        chk("momment_hold", 32'(phy.send_momment), 32'd40);
        phy.empty = 1'b1;
        wait_valid(d, t1);
        chk("after_full_data", 32'(d), 32'h11);
        step(1);
        phy.empty = 1'b0;
        step(2);
        phy.send_flag = 1'b0;
        fd = 0;
        repeat (4) begin
            @(negedge clock);
            if (frame_done) fd++;
        end
        chk("frame_done_once", 32'(fd), 32'd1);
        chk("end_state", 32'(dut.state), 32'(ST_IDLE));
        chk("end_momment", 32'(phy.send_momment), 32'd40);

        // Reset mid-frame in HOLD with level 5
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
            step(1);
        end
        wr_en = 1'b0;
        phy.send_flag = 1'b1;
        step(2);
        phy.empty = 1'b1;
        wait_valid(d, t1);
        chk("hold_pop_data", 32'(d), 32'h60);
        step(1);
        chk("hold_state", 32'(dut.state), 32'(ST_HOLD));
        chk("hold_level", 32'(level), 32'd5);
        rst = 1'b1;
        #1;
        chk_reset_outs("midrst");
        phy.send_flag = 1'b0;
        phy.empty = 1'b0;
        step(2);
        rst = 1'b0;
        fd = 0;
        repeat (4) begin
            @(negedge clock);
            if (frame_done) fd++;
        end
        chk("midrst_no_frame_done", 32'(fd), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
